// File: rtl/click_sequencer.sv
// click_sequencer: turns cursor clicks into single reveal / flag-toggle transactions for the
// mine_check stage, tracks per-cell revealed/flagged state and flag/reveal counts, and
// declares loss or win.
//
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   game_start_i, level_i    new-game pulse and board level (0/1 easy, 2 medium, 3 hard)
//   left_click_i             reveal request pulse
//   right_click_i            flag-toggle request pulse
//   cursor_ind_x_i/_y_i      clicked cell column / row
//   explode_in_i             mine_check explode result (valid in EVAL)
//   mark_flag_in_i           mine_check mark_flag result (valid in EVAL)
//   check_ind_x_o/_y_o       cell index to mine_check (latched click position)
//   bomb_o, flag_o           one-cycle reveal / flag strobes to mine_check
//   busy_o                   high while a click cannot be accepted
//   flag_cnt_o               number of flagged cells
//   revealed_cnt_o           number of safely revealed cells
//   game_over_o, game_won_o  game result levels
module click_sequencer #(
  parameter int unsigned EASY_MINES   = 10,
  parameter int unsigned MEDIUM_MINES = 20,
  parameter int unsigned HARD_MINES   = 40
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       game_start_i,
  input  logic [1:0] level_i,
  input  logic       left_click_i,
  input  logic       right_click_i,
  input  logic [4:0] cursor_ind_x_i,
  input  logic [4:0] cursor_ind_y_i,
  input  logic       explode_in_i,
  input  logic       mark_flag_in_i,
  output logic [4:0] check_ind_x_o,
  output logic [4:0] check_ind_y_o,
  output logic       bomb_o,
  output logic       flag_o,
  output logic       busy_o,
  output logic [5:0] flag_cnt_o,
  output logic [8:0] revealed_cnt_o,
  output logic       game_over_o,
  output logic       game_won_o
);

  typedef enum logic [2:0] {StIdle, StReady, StIssue, StEval, StLost, StWon} state_e;

  localparam logic [5:0] EasyMinesW   = 6'(EASY_MINES);
  localparam logic [5:0] MediumMinesW = 6'(MEDIUM_MINES);
  localparam logic [5:0] HardMinesW   = 6'(HARD_MINES);

  state_e       state_q, state_d;
  logic [1:0]   level_q, level_d;
  logic [4:0]   x_q, x_d, y_q, y_d;
  logic         op_flag_q, op_flag_d;   // 0: reveal, 1: flag toggle
  logic [255:0] revealed_q, revealed_d;
  logic [255:0] flagged_q, flagged_d;
  logic [5:0]   flag_cnt_q, flag_cnt_d;
  logic [8:0]   revealed_cnt_q, revealed_cnt_d;
  logic         bomb_q, bomb_d, flag_q, flag_d;
  logic         busy_q, busy_d, over_q, over_d, won_q, won_d;

  logic [4:0]   size;
  logic [5:0]   mines;
  logic [8:0]   cells;
  logic [8:0]   safe_cells;
  logic [7:0]   cur_idx, lat_idx;
  logic         in_range;

  // Board geometry from the latched level.
  always_comb begin
    size  = 5'd8;
    mines = EasyMinesW;
    cells = 9'd64;
    case (level_q)
      2'd2: begin
        size  = 5'd10;
        mines = MediumMinesW;
        cells = 9'd100;
      end
      2'd3: begin
        size  = 5'd16;
        mines = HardMinesW;
        cells = 9'd256;
      end
      default: ;
    endcase
    safe_cells = cells - {3'd0, mines};
  end

  // Low nibbles suffice: any in-range coordinate is below 16.
  assign cur_idx  = {cursor_ind_y_i[3:0], cursor_ind_x_i[3:0]};
  assign lat_idx  = {y_q[3:0], x_q[3:0]};
  assign in_range = (cursor_ind_x_i < size) && (cursor_ind_y_i < size);

  always_comb begin
    state_d        = state_q;
    level_d        = level_q;
    x_d            = x_q;
    y_d            = y_q;
    op_flag_d      = op_flag_q;
    revealed_d     = revealed_q;
    flagged_d      = flagged_q;
    flag_cnt_d     = flag_cnt_q;
    revealed_cnt_d = revealed_cnt_q;

    if (game_start_i) begin
      // New game wins over any click and abandons an in-flight transaction.
      state_d        = StReady;
      level_d        = level_i;
      revealed_d     = '0;
      flagged_d      = '0;
      flag_cnt_d     = '0;
      revealed_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StReady: begin
          if (left_click_i) begin
            // Left wins over a simultaneous right click, even if the reveal is dropped.
            if (in_range && !revealed_q[cur_idx] && !flagged_q[cur_idx]) begin
              x_d       = cursor_ind_x_i;
              y_d       = cursor_ind_y_i;
              op_flag_d = 1'b0;
              state_d   = StIssue;
            end
          end else if (right_click_i) begin
            if (in_range && !revealed_q[cur_idx] &&
                (flagged_q[cur_idx] || (flag_cnt_q != mines))) begin
              x_d       = cursor_ind_x_i;
              y_d       = cursor_ind_y_i;
              op_flag_d = 1'b1;
              state_d   = StIssue;
            end
          end
        end
        StIssue: state_d = StEval;
        StEval: begin
          if (!op_flag_q) begin
            if (explode_in_i) begin
              state_d = StLost;
            end else begin
              revealed_d[lat_idx] = 1'b1;
              revealed_cnt_d      = revealed_cnt_q + 9'd1;
              state_d = (revealed_cnt_d == safe_cells) ? StWon : StReady;
            end
          end else begin
            if (mark_flag_in_i) begin
              flagged_d[lat_idx] = ~flagged_q[lat_idx];
              flag_cnt_d = flagged_q[lat_idx] ? flag_cnt_q - 6'd1 : flag_cnt_q + 6'd1;
            end
            state_d = StReady;
          end
        end
        StLost: ;
        StWon: ;
        default: state_d = StIdle;
      endcase
    end

    // Outputs are registered versions of the decoded next state.
    bomb_d = (state_d == StIssue) && !op_flag_d;
    flag_d = (state_d == StIssue) && op_flag_d;
    busy_d = (state_d != StReady);
    over_d = (state_d == StLost);
    won_d  = (state_d == StWon);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      level_q        <= 2'd1;
      x_q            <= '0;
      y_q            <= '0;
      op_flag_q      <= 1'b0;
      revealed_q     <= '0;
      flagged_q      <= '0;
      flag_cnt_q     <= '0;
      revealed_cnt_q <= '0;
      bomb_q         <= 1'b0;
      flag_q         <= 1'b0;
      busy_q         <= 1'b0;  // reads 0 during reset, 1 from the first clock in IDLE
      over_q         <= 1'b0;
      won_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      level_q        <= level_d;
      x_q            <= x_d;
      y_q            <= y_d;
      op_flag_q      <= op_flag_d;
      revealed_q     <= revealed_d;
      flagged_q      <= flagged_d;
      flag_cnt_q     <= flag_cnt_d;
      revealed_cnt_q <= revealed_cnt_d;
      bomb_q         <= bomb_d;
      flag_q         <= flag_d;
      busy_q         <= busy_d;
      over_q         <= over_d;
      won_q          <= won_d;
    end
  end

  assign check_ind_x_o  = x_q;
  assign check_ind_y_o  = y_q;
  assign bomb_o         = bomb_q;
  assign flag_o         = flag_q;
  assign busy_o         = busy_q;
  assign flag_cnt_o     = flag_cnt_q;
  assign revealed_cnt_o = revealed_cnt_q;
  assign game_over_o    = over_q;
  assign game_won_o     = won_q;

endmodule

// File: tb/tb_click_sequencer.sv
// Testbench for click_sequencer: a reference model predicts every bomb/flag transaction,
// pushes it to a queue at click time, and a monitor pops and compares on each strobe.
module tb_click_sequencer;

  logic       clk, rst, game_start, left_click, right_click, explode_in, mark_flag_in;
  logic [1:0] level;
  logic [4:0] cursor_ind_x, cursor_ind_y, check_ind_x, check_ind_y;
  logic       bomb, flag, busy, game_over, game_won;
  logic [5:0] flag_cnt;
  logic [8:0] revealed_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  // Response the emulated mine_check returns for the current transaction.
  bit explode_next = 0;
  bit mark_next    = 0;

  // Reference model.
  bit m_rev[256];
  bit m_flg[256];
  int m_fcnt, m_rcnt, m_size, m_mines, m_safe;
  bit m_ready, m_over, m_won;

  click_sequencer dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .game_start_i   (game_start),
    .level_i        (level),
    .left_click_i   (left_click),
    .right_click_i  (right_click),
    .cursor_ind_x_i (cursor_ind_x),
    .cursor_ind_y_i (cursor_ind_y),
    .explode_in_i   (explode_in),
    .mark_flag_in_i (mark_flag_in),
    .check_ind_x_o  (check_ind_x),
    .check_ind_y_o  (check_ind_y),
    .bomb_o         (bomb),
    .flag_o         (flag),
    .busy_o         (busy),
    .flag_cnt_o     (flag_cnt),
    .revealed_cnt_o (revealed_cnt),
    .game_over_o    (game_over),
    .game_won_o     (game_won)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // mine_check stand-in: registered one-cycle response to the strobes.
  always @(posedge clk) begin
    explode_in   <= bomb & explode_next;
    mark_flag_in <= flag & mark_next;
  end

  // Monitor: every strobe must match the oldest predicted transaction.
  always @(negedge clk) begin
    if (bomb || flag) begin
      check("strobe_onehot", int'(bomb & flag), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 32'(flag) * 1024 + 32'(check_ind_y) * 32 + 32'(check_ind_x),
              -1);
      end else begin
        check("strobe_txn", 32'(flag) * 1024 + 32'(check_ind_y) * 32 + 32'(check_ind_x),
              exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) begin
      m_rev[i] = 0;
      m_flg[i] = 0;
    end
    m_fcnt = 0;
    m_rcnt = 0;
    m_over = 0;
    m_won  = 0;
  endtask

  task automatic model_level(input int lv);
    if (lv == 2) begin
      m_size = 10; m_mines = 20;
    end else if (lv == 3) begin
      m_size = 16; m_mines = 40;
    end else begin
      m_size = 8; m_mines = 10;
    end
    m_safe = m_size * m_size - m_mines;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_flag_cnt"}, int'(flag_cnt), m_fcnt);
    check({tag, "_revealed_cnt"}, int'(revealed_cnt), m_rcnt);
    check({tag, "_game_over"}, int'(game_over), int'(m_over));
    check({tag, "_game_won"}, int'(game_won), int'(m_won));
    check({tag, "_busy"}, int'(busy), int'(!m_ready));
  endtask

  task automatic start_game(input int lv);
    game_start = 1;
    level      = 2'(lv);
    tick();
    game_start = 0;
    model_clear();
    model_level(lv);
    m_ready = 1;
    check_state("start");
  endtask

  // One click; waits out a full transaction whether or not one is predicted.
  task automatic click(input string tag, input bit l, input bit r, input int x, input int y,
                       input bit expl, input bit mark);
    bit ok;
    int idx;
    idx = (y % 16) * 16 + (x % 16);
    ok  = m_ready && (l || r) && (x < m_size) && (y < m_size);
    if (ok && l) ok = !m_rev[idx] && !m_flg[idx];
    else if (ok) ok = !m_rev[idx] && (m_flg[idx] || (m_fcnt != m_mines));
    explode_next = expl;
    mark_next    = mark;
    left_click   = l;
    right_click  = r;
    cursor_ind_x = 5'(x);
    cursor_ind_y = 5'(y);
    if (ok) exp_q.push_back((l ? 0 : 1024) + y * 32 + x);
    tick();
    left_click  = 0;
    right_click = 0;
    tick();
    tick();
    if (ok) begin
      if (l) begin
        if (expl) begin
          m_over  = 1;
          m_ready = 0;
        end else begin
          m_rev[idx] = 1;
          m_rcnt++;
          if (m_rcnt == m_safe) begin
            m_won   = 1;
            m_ready = 0;
          end
        end
      end else if (mark) begin
        m_fcnt     = m_flg[idx] ? m_fcnt - 1 : m_fcnt + 1;
        m_flg[idx] = !m_flg[idx];
      end
    end
    check_state(tag);
  endtask

  initial begin
    rst = 1; game_start = 0; level = 0; left_click = 0; right_click = 0;
    cursor_ind_x = 0; cursor_ind_y = 0;
    model_clear();
    model_level(1);
    m_ready = 0;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_bomb", int'(bomb), 0);
    check("rst_flag", int'(flag), 0);
    check("rst_counts", int'(flag_cnt) + int'(revealed_cnt), 0);
    @(posedge clk);
    #1 rst = 0;
    tick();
    check_state("idle");
    click("idle_click", 1, 0, 1, 1, 0, 0);

    // Basic reveal at (3,2).
    start_game(1);
    click("reveal_3_2", 1, 0, 3, 2, 0, 0);

    // Flag toggle at (5,5), blocked reveal on a flagged cell, refused mark.
    click("flag_on", 0, 1, 5, 5, 0, 1);
    click("reveal_flagged", 1, 0, 5, 5, 0, 0);
    click("flag_off", 0, 1, 5, 5, 0, 1);
    click("flag_refused", 0, 1, 6, 6, 0, 0);

    // Clicks while busy are dropped.
    exp_q.push_back(2 * 32 + 2);
    explode_next = 0;
    left_click = 1; cursor_ind_x = 2; cursor_ind_y = 2;
    tick();
    cursor_ind_x = 4; cursor_ind_y = 4;
    tick();
    cursor_ind_x = 4; cursor_ind_y = 5;
    tick();
    left_click = 0;
    m_rev[2 * 16 + 2] = 1;
    m_rcnt++;
    check_state("busy_drop");

    click("left_right_same", 1, 1, 1, 1, 0, 1);
    click("repeat_reveal", 1, 0, 3, 2, 0, 0);
    click("flag_revealed", 0, 1, 3, 2, 0, 1);

    // Loss, then dead clicks, then restart.
    click("explode", 1, 0, 7, 7, 1, 0);
    click("lost_left", 1, 0, 0, 0, 0, 0);
    click("lost_right", 0, 1, 0, 0, 0, 1);
    start_game(1);

    // Flag cap: eleventh flag on level 1 is refused.
    for (int i = 0; i < 11; i++) click("flag_cap", 0, 1, i % 8, 7 - i / 8, 0, 1);
    click("unflag_at_cap", 0, 1, 0, 7, 0, 1);

    // Win after 54 safe reveals, with a repeat reveal mixed in.
    start_game(1);
    for (int i = 0; i < 54; i++) begin
      click("win_seq", 1, 0, i % 8, i / 8, 0, 0);
      if (i == 10) click("win_repeat", 1, 0, 0, 0, 0, 0);
    end
    click("won_click", 1, 0, 7, 7, 0, 0);

    // Level 2 geometry.
    start_game(2);
    click("l2_out_x12", 1, 0, 12, 3, 0, 0);
    click("l2_edge_x10", 1, 0, 10, 0, 0, 0);
    click("l2_in_9_9", 1, 0, 9, 9, 0, 0);

    // Level 3 corner.
    start_game(3);
    click("l3_15_15", 1, 0, 15, 15, 0, 0);
    click("l3_out_y16", 0, 1, 0, 16, 0, 1);

    // game_start during EVAL abandons the reveal.
    start_game(1);
    exp_q.push_back(0 * 32 + 6);
    explode_next = 0;
    left_click = 1; cursor_ind_x = 6; cursor_ind_y = 0;
    tick();
    left_click = 0;
    tick();
    game_start = 1; level = 1;
    tick();
    game_start = 0;
    model_clear();
    m_ready = 1;
    check_state("gs_in_eval");

    // Asynchronous reset during ISSUE.
    left_click = 1; cursor_ind_x = 3; cursor_ind_y = 1;
    tick();
    left_click = 0;
    check("issue_bomb", int'(bomb), 1);
    rst = 1;
    #1;
    check("arst_bomb", int'(bomb), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_ind", int'(check_ind_x) + int'(check_ind_y), 0);
    check("arst_counts", int'(flag_cnt) + int'(revealed_cnt), 0);
    @(posedge clk);
    #1 rst = 0;
    tick();
    model_clear();
    model_level(1);
    m_ready = 0;
    check_state("post_rst_idle");
    click("post_rst_click", 1, 0, 1, 1, 0, 0);
    start_game(1);
    click("post_rst_reveal", 1, 0, 0, 0, 0, 0);

    tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/click_sequencer.md
Name: click_sequencer

Overview:
- Game-level controller that turns cursor clicks into single transactions for the mine-check stage.
- Left click = reveal, right click = flag toggle.
- Holds exactly one request in flight at a time. Tracks per-cell revealed and flagged state, maintains flag and reveal counters, and declares loss or win.
- Sits between the mouse/cursor logic and mine_check; drives mine_check's flag/bomb/index inputs and consumes its explode/mark_flag outputs.

Parameters:
- EASY_MINES, 10, mine count for level 1/0 (8x8 board)
- MEDIUM_MINES, 20, mine count for level 2 (10x10 board)
- HARD_MINES, 40, mine count for level 3 (16x16 board)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- game_start  in  1  one-cycle pulse; clears the board and latches level
- level  in  2  board level (0 or 1 = easy, 2 = medium, 3 = hard)
- left_click  in  1  one-cycle pulse; reveal request
- right_click  in  1  one-cycle pulse; flag-toggle request
- cursor_ind_x  in  5  column index of the clicked cell
- cursor_ind_y  in  5  row index of the clicked cell
- explode_in  in  1  mine_check registered explode result
- mark_flag_in  in  1  mine_check registered mark_flag result
- check_ind_x  out  5  column index to mine_check
- check_ind_y  out  5  row index to mine_check
- bomb  out  1  reveal strobe to mine_check
- flag  out  1  flag strobe to mine_check
- busy  out  1  high while not able to accept a click
- flag_cnt  out  6  number of flagged cells
- revealed_cnt  out  9  number of safely revealed cells
- game_over  out  1  level, mine revealed
- game_won  out  1  level, all safe cells revealed

Behaviour:
- Async reset, all registered. State = IDLE. All outputs 0. Revealed and flagged maps cleared. Latched level = 1.
- Board geometry from latched level:
  - size 8/10/16, mines EASY/MEDIUM/HARD_MINES.
  - safe_cells = size*size - mines, i.e. 54 / 80 / 216 with defaults.
- States and transitions:
  - IDLE: busy = 1. Clicks ignored. game_start -> READY.
  - READY: busy = 0.
    - A valid click in cycle C latches x, y and the operation, then goes to ISSUE.
    - left_click and right_click in the same cycle: left wins, right dropped.
  - ISSUE (C+1): check_ind_x/y = latched x/y. Exactly one of bomb/flag = 1 for this single cycle. Next state is EVAL.
  - EVAL (C+2): samples explode_in / mark_flag_in, which are valid this cycle because mine_check has 1-cycle registered latency.
    - Reveal:
      - explode_in = 1 -> LOST.
      - Otherwise set the revealed bit and increment revealed_cnt. If the new count equals safe_cells -> WON, else READY.
    - Flag:
      - If mark_flag_in = 1, toggle the flagged bit and adjust flag_cnt by +1 or -1, then READY.
      - If mark_flag_in = 0, no change, then READY.
  - LOST: game_over = 1, busy = 1. Holds until game_start.
  - WON: game_won = 1, busy = 1. Holds until game_start.
- Click validity: a click is dropped with no transaction and no state change when any of these holds:
  - x >= size or y >= size.
  - Reveal on a flagged or already-revealed cell.
  - Flag on a revealed cell.
  - Flag on an unflagged cell while flag_cnt == mines.
- Clicks arriving in ISSUE, EVAL, LOST, WON or IDLE are dropped; there is no queue.
- bomb and flag are 0 in every state except ISSUE. check_ind_x/y hold their last value outside ISSUE.
- game_start in any state, including mid-transaction:
  - Next state READY.
  - Clears both maps, flag_cnt, revealed_cnt, game_over and game_won.
  - Latches level. Any in-flight transaction is abandoned with no update.
  - game_start has priority over a click in the same cycle.
- Maps: 256-bit revealed map and 256-bit flagged map, indexed y*16 + x. Cells outside the current size are never written.
- Counter widths are sufficient; no saturation or wrap is reachable.

Test Plan:
- Reset, game_start with level=1, left_click at (3,2) in cycle C:
  - bomb=1 with check_ind=(3,2) at C+1 only.
  - explode_in=0 at C+2 -> revealed_cnt=1 and busy=0 at C+3.
- Reveal a cell with explode_in=1 at EVAL -> game_over=1. Subsequent clicks produce no bomb/flag pulses. game_start -> game_over=0 and counts=0.
- right_click at (5,5) twice, mark_flag_in=1 each time:
  - flag_cnt goes 1 then 0.
  - A left_click on (5,5) while flagged produces no bomb pulse.
- left_click pulses at C+1 and C+2 while busy: ignored, only one bomb pulse. Simultaneous left and right at (1,1): only bomb pulses.
- Level 1, 54 distinct safe reveals -> game_won=1 after the 54th EVAL. A repeat reveal of a revealed cell is ignored and the count does not change.
- Level 2, click (12,3) -> dropped.
- Assert rst during ISSUE -> all outputs 0 immediately (async) and state IDLE.
- game_start during EVAL -> no counter update, state READY.
